// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank: writable multi-palette colour lookup with transparency and hit-flash
module sprite_palette_bank #(
    parameter int INDEX_W      = 3,
    parameter int NUM_PAL      = 4,
    parameter int PAL_W        = 2,
    parameter int COLOR_W      = 4,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 wr_en,
    input  logic [PAL_W-1:0]     wr_pal,
    input  logic [INDEX_W-1:0]   wr_idx,
    input  logic [3*COLOR_W-1:0] wr_rgb,
    input  logic                 rd_valid,
    input  logic [PAL_W-1:0]     rd_pal,
    input  logic [INDEX_W-1:0]   rd_idx,
    input  logic                 frame_tick,
    input  logic                 flash_start,
    output logic                 out_valid,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 transparent,
    output logic                 flash_active
);
    localparam int ENT = 1 << INDEX_W;
    localparam logic [11:0] DEF [8] = '{12'h000, 12'h0E0, 12'h976, 12'hB20,
                                        12'hDBB, 12'h060, 12'h443, 12'h400};

    // Default palette-0 entry, each 4-bit channel resized to COLOR_W
    function automatic logic [3*COLOR_W-1:0] def_rgb(input int i);
        logic [11:0] d;
        d = (i < 8) ? DEF[i[2:0]] : 12'h000;
        return {COLOR_W'(d[11:8]), COLOR_W'(d[7:4]), COLOR_W'(d[3:0])};
    endfunction

    logic [3*COLOR_W-1:0] mem [NUM_PAL][ENT];
    logic [3*COLOR_W-1:0] pal_word;
    logic [3*COLOR_W-1:0] rgb_q;
    logic                 pal_ok;
    logic                 hit;
    logic                 tr;
    logic                 flash;
    logic [7:0]           cnt;

    // Palette storage: reset to defaults, written only for an existing palette
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int p = 0; p < NUM_PAL; p++)
                for (int i = 0; i < ENT; i++)
                    mem[p][i] <= (p == 0) ? def_rgb(i) : '0;
        end else if (wr_en) begin
            for (int p = 0; p < NUM_PAL; p++)
                if (wr_pal == PAL_W'(p)) mem[p][wr_idx] <= wr_rgb;
        end
    end

    // Palette select mux; an out-of-range palette matches nothing
    always_comb begin
        pal_word = '0;
        pal_ok   = 1'b0;
        for (int p = 0; p < NUM_PAL; p++) begin
            if (rd_pal == PAL_W'(p)) begin
                pal_word = mem[p][rd_idx];
                pal_ok   = 1'b1;
            end
        end
    end

    assign hit   = wr_en && pal_ok && (wr_pal == rd_pal) && (wr_idx == rd_idx);
    assign tr    = !pal_ok || (rd_idx == '0);
    assign flash = (cnt != 8'd0) && cnt[0];

    // Registered lookup: write-first bypass, transparency, flash whitening
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid   <= 1'b0;
            transparent <= 1'b1;
            rgb_q       <= '0;
        end else begin
            out_valid <= rd_valid;
            if (rd_valid) begin
                transparent <= tr;
                rgb_q       <= tr ? '0 : flash ? '1 : hit ? wr_rgb : pal_word;
            end
        end
    end

    // Flash episode counter: start (re)loads, frame ticks count down to zero
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            cnt <= 8'd0;
        else if (flash_start)
            cnt <= 8'(FLASH_FRAMES);
        else if (frame_tick && cnt != 8'd0)
            cnt <= cnt - 8'd1;
    end

    assign {red, green, blue} = rgb_q;
    assign flash_active       = cnt != 8'd0;
endmodule

// File: tb/tb_sprite_palette_bank.sv
// tb_sprite_palette_bank: table-driven and directed checks of the sprite palette bank
module tb_sprite_palette_bank;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        wr_en;
    logic [1:0]  wr_pal;
    logic [2:0]  wr_idx;
    logic [11:0] wr_rgb;
    logic        rd_valid;
    logic [1:0]  rd_pal;
    logic [2:0]  rd_idx;
    logic        frame_tick;
    logic        flash_start;
    logic        out_valid;
    logic [3:0]  red, green, blue;
    logic        transparent;
    logic        flash_active;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [1:0]  wp;
        logic [2:0]  wi;
        logic [11:0] wd;
        logic        rv;
        logic [1:0]  rp;
        logic [2:0]  ri;
        logic        ev;
        logic [11:0] ergb;
        logic        etr;
    } vec_t;

    vec_t vt [21];

    sprite_palette_bank #(
        .INDEX_W(3), .NUM_PAL(3), .PAL_W(2), .COLOR_W(4), .FLASH_FRAMES(4)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .wr_en(wr_en), .wr_pal(wr_pal), .wr_idx(wr_idx),
        .wr_rgb(wr_rgb), .rd_valid(rd_valid), .rd_pal(rd_pal), .rd_idx(rd_idx),
        .frame_tick(frame_tick), .flash_start(flash_start), .out_valid(out_valid),
        .red(red), .green(green), .blue(blue), .transparent(transparent),
        .flash_active(flash_active)
    );

    always #5 Clk = ~Clk;

    function automatic vec_t mk(logic we, logic [1:0] wp, logic [2:0] wi, logic [11:0] wd,
                                logic rv, logic [1:0] rp, logic [2:0] ri,
                                logic ev, logic [11:0] ergb, logic etr);
        vec_t v;
        v.we = we; v.wp = wp; v.wi = wi; v.wd = wd;
        v.rv = rv; v.rp = rp; v.ri = ri;
        v.ev = ev; v.ergb = ergb; v.etr = etr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        run(1);
        frame_tick = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [11:0] rgb, input logic t);
        chk({name, ".valid"}, 32'(out_valid), 32'(v));
        chk({name, ".rgb"}, 32'({red, green, blue}), 32'(rgb));
        chk({name, ".transparent"}, 32'(transparent), 32'(t));
    endtask

    initial begin
        Reset_n = 1'b0; wr_en = 1'b0; wr_pal = '0; wr_idx = '0; wr_rgb = '0;
        rd_valid = 1'b0; rd_pal = '0; rd_idx = '0; frame_tick = 1'b0; flash_start = 1'b0;

        vt[0]  = mk(0, 0, 0, 12'h000, 1, 0, 1, 1, 12'h0E0, 0);
        vt[1]  = mk(0, 0, 0, 12'h000, 1, 0, 2, 1, 12'h976, 0);
        vt[2]  = mk(0, 0, 0, 12'h000, 1, 0, 3, 1, 12'hB20, 0);
        vt[3]  = mk(0, 0, 0, 12'h000, 1, 0, 4, 1, 12'hDBB, 0);
        vt[4]  = mk(0, 0, 0, 12'h000, 1, 0, 5, 1, 12'h060, 0);
        vt[5]  = mk(0, 0, 0, 12'h000, 1, 0, 6, 1, 12'h443, 0);
        vt[6]  = mk(0, 0, 0, 12'h000, 1, 0, 7, 1, 12'h400, 0);
        vt[7]  = mk(0, 0, 0, 12'h000, 1, 0, 0, 1, 12'h000, 1);
        vt[8]  = mk(0, 0, 0, 12'h000, 1, 3, 0, 1, 12'h000, 1);
        vt[9]  = mk(1, 2, 5, 12'hABC, 0, 0, 1, 0, 12'h000, 1);
        vt[10] = mk(0, 0, 0, 12'h000, 1, 2, 5, 1, 12'hABC, 0);
        vt[11] = mk(1, 2, 5, 12'h123, 1, 2, 5, 1, 12'h123, 0);
        vt[12] = mk(0, 0, 0, 12'h000, 1, 2, 5, 1, 12'h123, 0);
        vt[13] = mk(1, 3, 4, 12'hFFF, 0, 0, 0, 0, 12'h123, 0);
        vt[14] = mk(0, 0, 0, 12'h000, 1, 3, 4, 1, 12'h000, 1);
        vt[15] = mk(1, 1, 2, 12'h5A5, 1, 1, 2, 1, 12'h5A5, 0);
        vt[16] = mk(0, 0, 0, 12'h000, 1, 0, 2, 1, 12'h976, 0);
        vt[17] = mk(0, 0, 0, 12'h000, 1, 1, 2, 1, 12'h5A5, 0);
        vt[18] = mk(1, 1, 3, 12'h777, 1, 1, 2, 1, 12'h5A5, 0);
        vt[19] = mk(0, 0, 0, 12'h000, 1, 1, 3, 1, 12'h777, 0);
        vt[20] = mk(0, 0, 0, 12'h000, 0, 0, 1, 0, 12'h777, 0);

        #12;
        chk_out("reset", 1'b0, 12'h000, 1'b1);
        chk("reset.flash_active", 32'(flash_active), 32'd0);
        Reset_n = 1'b1;
        run(1);

        for (int k = 0; k < 21; k++) begin
            wr_en = vt[k].we; wr_pal = vt[k].wp; wr_idx = vt[k].wi; wr_rgb = vt[k].wd;
            rd_valid = vt[k].rv; rd_pal = vt[k].rp; rd_idx = vt[k].ri;
            run(1);
            chk_out($sformatf("vec%0d", k), vt[k].ev, vt[k].ergb, vt[k].etr);
        end
        wr_en = 1'b0;

        rd_valid = 1'b1; rd_pal = 2'd0; rd_idx = 3'd3;
        flash_start = 1'b1;
        run(1);
        flash_start = 1'b0;
        for (int c = 4; c >= 0; c--) begin
            run(2);
            chk($sformatf("flash%0d.rgb", c), 32'({red, green, blue}),
                (c % 2 == 1) ? 32'hFFF : 32'hB20);
            chk($sformatf("flash%0d.active", c), 32'(flash_active), 32'(c != 0));
            chk($sformatf("flash%0d.transparent", c), 32'(transparent), 32'd0);
            if (c > 0) begin
                run(7);
                tick();
            end
        end
        tick();
        run(2);
        chk("nowrap.active", 32'(flash_active), 32'd0);
        chk("nowrap.rgb", 32'({red, green, blue}), 32'hB20);

        flash_start = 1'b1;
        run(1);
        flash_start = 1'b0;
        tick();
        tick();
        flash_start = 1'b1; frame_tick = 1'b1;
        run(1);
        flash_start = 1'b0; frame_tick = 1'b0;
        run(2);
        chk("coinc.rgb", 32'({red, green, blue}), 32'hB20);
        chk("coinc.active", 32'(flash_active), 32'd1);
        tick();
        run(2);
        chk("coinc3.rgb", 32'({red, green, blue}), 32'hFFF);
        rd_idx = 3'd0;
        run(1);
        chk_out("flash_idx0", 1'b1, 12'h000, 1'b1);
        rd_idx = 3'd3;
        run(1);
        chk("flash_back.rgb", 32'({red, green, blue}), 32'hFFF);

        #2 Reset_n = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, 12'h000, 1'b1);
        chk("async_reset.active", 32'(flash_active), 32'd0);
        rd_valid = 1'b0;
        #3 Reset_n = 1'b1;
        rd_valid = 1'b1; rd_pal = 2'd1; rd_idx = 3'd2;
        run(1);
        chk_out("post_reset_pal1", 1'b1, 12'h000, 1'b0);
        rd_pal = 2'd0; rd_idx = 3'd7;
        run(1);
        chk_out("post_reset_pal0", 1'b1, 12'h400, 1'b0);
        rd_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
